frame_writer: RTL and testbench

//  Write-side producer for the 12-bpp frame buffer. Accepts a stream of 12-bit RGB444 pixels,

---
 rtl/frame_writer.sv | 141 ++++++++++++++
 tb/tb_frame_writer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// Packs pairs of RGB444 pixels into 24-bit words and writes them to sequential frame-buffer addresses.
// Optional FRAME_WRITER_CNT_EN adds an 8-bit wrapping count of completed frames (o_frame_cnt).
module frame_writer #(
  parameter int WORDS = 2048,
  parameter int AW    = 11,
  parameter int PW    = 12
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_px_valid,
  output logic            o_px_ready,
  input  logic [PW-1:0]   i_px_data,
  input  logic            i_px_sof,
  input  logic            i_freeze,
  output logic            o_we_a,
  output logic [AW-1:0]   o_w_address,
  output logic [2*PW-1:0] o_w_data,
  output logic            o_frame_done,
`ifdef FRAME_WRITER_CNT_EN
  output logic [7:0]      o_frame_cnt,
`endif
  output logic            o_sync_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_ptr;
  logic [PW-1:0]     r_rgb0;
  logic              r_we;
  logic [AW-1:0]     r_addr;
  logic [2*PW-1:0]   r_data;
  logic              r_done;
  logic              r_err;

  state_t            w_state_nxt;
  logic [AW-1:0]     w_ptr_nxt;
  logic [PW-1:0]     w_rgb0_nxt;
  logic              w_we_nxt;
  logic [AW-1:0]     w_addr_nxt;
  logic [2*PW-1:0]   w_data_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic              w_ready;
  logic              w_acc;
  logic              w_last;

  // Freeze only gates frame starts; an in-progress frame always drains.
  assign w_ready = ~i_rst & ~((r_state == IDLE) & i_freeze);
  assign w_acc   = i_px_valid & w_ready;
  assign w_last  = (r_ptr == AW'(WORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_rgb0_nxt  = r_rgb0;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_acc) begin
      if (i_px_sof) begin
        // A start-of-frame always restarts packing; mid-frame it drops any half word.
        w_err_nxt   = (r_state != IDLE);
        w_rgb0_nxt  = i_px_data;
        w_ptr_nxt   = '0;
        w_state_nxt = ODD;
      end else begin
        case (r_state)
          EVEN: begin
            w_rgb0_nxt  = i_px_data;
            w_state_nxt = ODD;
          end
          ODD: begin
            w_we_nxt   = 1'b1;
            w_addr_nxt = r_ptr;
            w_data_nxt = {r_rgb0, i_px_data};
            if (w_last) begin
              w_done_nxt  = 1'b1;
              w_ptr_nxt   = '0;
              w_state_nxt = IDLE;
            end else begin
              w_ptr_nxt   = r_ptr + 1'b1;
              w_state_nxt = EVEN;
            end
          end
          default: w_state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_rgb0  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_rgb0  <= w_rgb0_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

`ifdef FRAME_WRITER_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_cnt <= 8'd0;
    end else if (w_done_nxt) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

  assign o_px_ready   = w_ready;
  assign o_we_a       = r_we;
  assign o_w_address  = r_addr;
  assign o_w_data     = r_data;
  assign o_frame_done = r_done;
  assign o_sync_err   = r_err;

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer (WORDS=4): a pixel-count reference model queues expected writes
// and sync errors with their due cycle; a negedge monitor compares every cycle.
module tb_frame_writer;
  localparam int WORDS = 4;
  localparam int AW    = 3;
  localparam int PW    = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            px_valid = 1'b0;
  logic            px_ready;
  logic [PW-1:0]   px_data = '0;
  logic            px_sof = 1'b0;
  logic            freeze = 1'b0;
  logic            we_a;
  logic [AW-1:0]   w_address;
  logic [2*PW-1:0] w_data;
  logic            frame_done;
  logic            sync_err;
`ifdef FRAME_WRITER_CNT_EN
  logic [7:0]      frame_cnt;
`endif

  frame_writer #(.WORDS(WORDS), .AW(AW), .PW(PW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_px_valid  (px_valid),
    .o_px_ready  (px_ready),
    .i_px_data   (px_data),
    .i_px_sof    (px_sof),
    .i_freeze    (freeze),
    .o_we_a      (we_a),
    .o_w_address (w_address),
    .o_w_data    (w_data),
    .o_frame_done(frame_done),
`ifdef FRAME_WRITER_CNT_EN
    .o_frame_cnt (frame_cnt),
`endif
    .o_sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              due;
    logic [AW-1:0]   addr;
    logic [2*PW-1:0] data;
    bit              done;
  } wr_t;

  wr_t wq[$];
  int  eq[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  started = 0;
  bit  exp_ready = 0;
  int  rst_due = -1;

  // reference model state: position of the next pixel within the current frame
  bit              in_frame = 0;
  int              npx = 0;
  logic [PW-1:0]   first_px = '0;
  logic [AW-1:0]   last_addr = '0;
  logic [2*PW-1:0] last_data = '0;
  int              exp_cnt = 0;
  bit              frz = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      bit exp_we;
      bit exp_err;
      if (cyc == rst_due) begin
        last_addr = '0;
        last_data = '0;
        exp_cnt   = 0;
      end
      while (wq.size() > 0 && wq[0].due < cyc) begin
        chk("stale_write", 32'(wq[0].due), 32'(cyc));
        void'(wq.pop_front());
      end
      while (eq.size() > 0 && eq[0] < cyc) begin
        chk("stale_sync_err", 32'(eq[0]), 32'(cyc));
        void'(eq.pop_front());
      end
      chk("px_ready", 32'(px_ready), 32'(exp_ready));
      exp_we = (wq.size() > 0 && wq[0].due == cyc);
      chk("we_a", 32'(we_a), 32'(exp_we));
      if (exp_we) begin
        wr_t w;
        w = wq.pop_front();
        last_addr = w.addr;
        last_data = w.data;
        if (w.done) exp_cnt = (exp_cnt + 1) % 256;
        chk("frame_done", 32'(frame_done), 32'(w.done));
      end else begin
        chk("frame_done_idle", 32'(frame_done), 32'(0));
      end
      chk("w_address", 32'(w_address), 32'(last_addr));
      chk("w_data", 32'(w_data), 32'(last_data));
`ifdef FRAME_WRITER_CNT_EN
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
`endif
      exp_err = (eq.size() > 0 && eq[0] == cyc);
      chk("sync_err", 32'(sync_err), 32'(exp_err));
      if (exp_err) void'(eq.pop_front());
    end
  end

  // Drive one cycle of inputs and predict the outcome of the upcoming edge.
  task automatic drive(input bit r, input bit v, input bit s, input logic [PW-1:0] d);
    @(posedge clk);
    #2;
    rst = r; px_valid = v; px_sof = s; px_data = d; freeze = frz;
    exp_ready = !r && !(frz && !in_frame);
    started = 1;
    if (r) begin
      in_frame = 0;
      npx = 0;
      rst_due = cyc + 1;
    end else if (v && exp_ready) begin
      if (s) begin
        if (in_frame) eq.push_back(cyc + 1);
        in_frame = 1;
        first_px = d;
        npx = 1;
      end else if (in_frame) begin
        npx++;
        if (npx % 2 == 1) begin
          first_px = d;
        end else begin
          wq.push_back('{due: cyc + 1, addr: AW'(npx / 2 - 1), data: {first_px, d},
                         done: (npx / 2 == WORDS)});
          if (npx == 2 * WORDS) in_frame = 0;
        end
      end
    end
  endtask

  task automatic px(input bit s, input logic [PW-1:0] d);
    drive(0, 1, s, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0);
  endtask

  initial begin
    // reset held with a valid source: nothing accepted, nothing written
    drive(1, 1, 1, 12'hFFF);
    drive(1, 1, 0, 12'hEEE);
    idle(2);

    // pack a single word
    px(1, 12'hABC); px(0, 12'h123);
    idle(2);
    drive(1, 0, 0, '0); idle(1);

    // full frame, back to back
    px(1, 12'h001);
    for (int i = 2; i <= 8; i++) px(0, PW'(i));
    idle(3);

    // pixels before sof are dropped
    px(0, 12'h321); px(0, 12'h654); px(0, 12'h987);
    px(1, 12'h111); px(0, 12'h222);
    idle(2);

    // resync mid-frame discards the pending half word
    drive(1, 0, 0, '0); idle(1);
    px(1, 12'h0AA); px(0, 12'h0BB); px(0, 12'h0CC);
    px(1, 12'h0DD); px(0, 12'h0EE);
    idle(2);

    // sof without valid is ignored
    drive(0, 0, 1, 12'h555);
    idle(1);

    // freeze mid-frame lets the frame finish, then holds off the next one
    drive(1, 0, 0, '0); idle(1);
    px(1, 12'h101); px(0, 12'h102); px(0, 12'h103);
    frz = 1;
    for (int i = 4; i <= 8; i++) px(0, PW'(12'h100 + i));
    px(1, 12'h777); px(0, 12'h778);
    idle(2);
    frz = 0;
    px(1, 12'h201);
    for (int i = 2; i <= 8; i++) px(0, PW'(12'h200 + i));
    idle(2);

    // randomized traffic with occasional sof, freeze, reset and gaps
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) frz = ~frz;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 24) == 0, PW'($urandom));
    end
    frz = 0;
    idle(4);

    chk("writes_drained", 32'(wq.size()), 32'(0));
    chk("errors_drained", 32'(eq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
